// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO.
// Radix-2 shift-add multiply and restoring divide retire one bit per clock.
// Operands are reduced to magnitudes on launch. The sign is reapplied in a
// single fix-up cycle, and only then are hi/lo updated.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Magnitude of a possibly signed operand. Unsigned operands pass through
  // unchanged. The most negative value maps onto itself, which is still the
  // correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v,
                                             input logic             is_signed);
    logic signed [WIDTH-1:0] s;
    s = v;
    if (is_signed && s < 0) begin
      return $unsigned(-s);
    end
    return v;
  endfunction

  // Conditional two's-complement negate, single width.
  function automatic logic [WIDTH-1:0] f_neg_w(input logic [WIDTH-1:0] v,
                                               input logic             en);
    return en ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Conditional two's-complement negate, double width (product).
  function automatic logic [2*WIDTH-1:0] f_neg_2w(input logic [2*WIDTH-1:0] v,
                                                  input logic               en);
    return en ? (~v + {{(2*WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Control state
  state_t          r_state;
  logic            r_busy;
  logic            r_done;
  logic [CW-1:0]   r_count;
  logic            r_is_div;
  logic            r_sign_q;
  logic            r_sign_r;
  logic            r_div_zero;

  // Scratch datapath.
  // For multiply, r_hs:r_ls is the {accumulator, multiplier} shift pair.
  // For divide, r_hs is the partial remainder and r_ls the dividend, which
  // is shifted out while quotient bits are shifted in.
  logic [WIDTH-1:0] r_hs;
  logic [WIDTH-1:0] r_ls;
  logic [WIDTH-1:0] r_b;

  // Architectural registers
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Launch-time operand conditioning
  logic             w_signed_op;
  logic             w_is_div;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_signed_op = ~op[0];
  assign w_is_div    = op[1];
  assign w_a_mag     = f_mag(a, w_signed_op);
  assign w_b_mag     = f_mag(b, w_signed_op);

  // Multiply step: conditional add of the multiplicand, with the carry kept
  // so that the right shift preserves it.
  logic [WIDTH:0] w_msum;
  assign w_msum = {1'b0, r_hs} + (r_ls[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

  // Divide step: shift the next dividend bit into the remainder, then do a
  // trial subtraction. Because the remainder is always below the divisor,
  // the shifted value fits in WIDTH+1 bits. One extra bit exposes the borrow.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_fits;
  logic             w_unused_diff;

  assign w_shift       = {r_hs, r_ls[WIDTH-1]};
  assign w_diff        = {1'b0, w_shift} - {2'b00, r_b};
  assign w_fits        = ~w_diff[WIDTH+1];
  assign w_unused_diff = w_diff[WIDTH];

  // Sign fix-up of the finished magnitudes
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_prod_fix = f_neg_2w({r_hs, r_ls}, r_sign_q);
  assign w_quo_fix  = r_div_zero ? {WIDTH{1'b1}} : f_neg_w(r_ls, r_sign_q);
  assign w_rem_fix  = f_neg_w(r_hs, r_sign_r);

  // Sequencer: launch, iterate, fix up, and handle MTHI/MTLO while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_count    <= '0;
      r_is_div   <= 1'b0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_div_zero <= 1'b0;
      r_hs       <= '0;
      r_ls       <= '0;
      r_b        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Any MTHI/MTLO request in the same cycle is dropped.
            r_state    <= S_RUN;
            r_busy     <= 1'b1;
            r_count    <= '0;
            r_is_div   <= w_is_div;
            r_sign_q   <= w_signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_sign_r   <= w_signed_op & a[WIDTH-1];
            r_div_zero <= w_is_div & (b == '0);
            r_hs       <= '0;
            r_ls       <= w_a_mag;
            r_b        <= w_b_mag;
          end else begin
            if (we_hi) begin
              r_hi <= wd;
            end
            if (we_lo) begin
              r_lo <= wd;
            end
          end
        end

        S_RUN: begin
          if (r_is_div) begin
            r_hs <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_ls <= {r_ls[WIDTH-2:0], w_fits};
          end else begin
            r_hs <= w_msum[WIDTH:1];
            r_ls <= {w_msum[0], r_ls[WIDTH-1:1]};
          end
          r_count <= r_count + CW'(1);
          if (r_count == LAST) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_count <= '0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized scoreboard bench for mul_div_unit. Each launch pushes the expected
// HI/LO pair and the expected done cycle. A negedge monitor pops and compares
// each entry when done pulses, and while busy it checks that HI/LO hold steady.
module tb_mul_div_unit;
  localparam int W = 32;
  localparam int LAT = 33;  // edges from the accepting edge to the done edge

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b, wd;
  logic         we_hi, we_lo;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .we_hi(we_hi), .we_lo(we_lo), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_pass = 0;
  int           n_tot  = 0;
  logic [W-1:0] hold_hi = '0;
  logic [W-1:0] hold_lo = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
  endtask

  // Reference model: plain integer arithmetic on the architectural rules.
  function automatic logic [2*W-1:0] model(input logic [1:0] o,
                                           input logic [W-1:0] x, input logic [W-1:0] y);
    longint          sx, sy, sq, sr;
    logic [2*W-1:0]  ux, uy, res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {{W{1'b0}}, x};
    uy = {{W{1'b0}}, y};
    case (o)
      2'b00: begin sq = sx * sy; res = sq; end
      2'b01: res = ux * uy;
      2'b10: begin
        if (y == '0) res = {x, {W{1'b1}}};
        else begin
          sq = sx / sy;
          sr = sx % sy;
          res = {sr[W-1:0], sq[W-1:0]};
        end
      end
      default: begin
        if (y == '0) res = {x, {W{1'b1}}};
        else res = {ux[W-1:0] % uy[W-1:0], ux[W-1:0] / uy[W-1:0]};
      end
    endcase
    return res;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return {W{1'b1}};
      2: return {1'b1, {(W-1){1'b0}}};
      3: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: score completed operations, and check that HI/LO hold while busy.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("result_hi", 64'(hi), 64'(mon_e.hi));
          chk("result_lo", 64'(lo), 64'(mon_e.lo));
          chk("done_latency", 64'(cyc), 64'(mon_e.cyc + LAT));
          hold_hi = mon_e.hi;
          hold_lo = mon_e.lo;
        end
      end else if (busy) begin
        chk("hi_hold_busy", 64'(hi), 64'(hold_hi));
        chk("lo_hold_busy", 64'(lo), 64'(hold_lo));
      end
    end
  end

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("busy_timeout", 64'd1, 64'd0);
  endtask

  // Present a launch at a negedge. Optionally record its expectation, and
  // optionally raise MTHI/MTLO in the same cycle (that write must be dropped).
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit push, input bit mt);
    exp_t e;
    logic [2*W-1:0] r;
    wait_idle();
    start = 1'b1; op = o; a = x; b = y;
    we_hi = mt; we_lo = mt; wd = W'($urandom);
    if (push) begin
      r = model(o, x, y);
      e.hi = r[2*W-1:W];
      e.lo = r[W-1:0];
      e.cyc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_tot);
    $fatal(1);
  end

  initial begin
    int guard;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    we_hi = 1'b0; we_lo = 1'b0; wd = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // MTHI / MTLO while idle
    we_hi = 1'b1; wd = 32'hCAFEBABE;
    @(negedge clk);
    we_hi = 1'b0;
    chk("mthi", 64'(hi), 64'hCAFEBABE);
    chk("mthi_busy", 64'(busy), 64'd0);
    we_lo = 1'b1; wd = 32'h5;
    @(negedge clk);
    we_lo = 1'b0;
    chk("mtlo", 64'(lo), 64'h5);
    chk("mtlo_hi_kept", 64'(hi), 64'hCAFEBABE);
    we_hi = 1'b1; we_lo = 1'b1; wd = 32'h13579BDF;
    @(negedge clk);
    we_hi = 1'b0; we_lo = 1'b0;
    chk("mthi_both", 64'(hi), 64'h13579BDF);
    chk("mtlo_both", 64'(lo), 64'h13579BDF);
    hold_hi = 32'h13579BDF;
    hold_lo = 32'h13579BDF;

    // Directed corner cases
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
    issue(2'b00, 32'hFFFFFFFD, 32'h00000005, 1, 0);
    issue(2'b00, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0);
    issue(2'b10, 32'hFFFFFFF9, 32'h00000002, 1, 0);
    issue(2'b11, 32'h00000007, 32'h00000002, 1, 0);
    issue(2'b10, 32'h00001234, 32'h00000000, 1, 0);
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1, 0);
    issue(2'b10, 32'hFFFFFF00, 32'h00000000, 1, 1);
    issue(2'b11, 32'h80000001, 32'h00000000, 1, 0);
    issue(2'b00, 32'h80000000, 32'h80000000, 1, 0);

    // A second start and an MTHI while busy are both ignored.
    issue(2'b01, 32'hDEADBEEF, 32'h12345678, 1, 0);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'h1; b = 32'h1;
    we_hi = 1'b1; wd = 32'h0BADF00D;
    @(negedge clk);
    start = 1'b0; we_hi = 1'b0;

    // Reset in mid-operation clears the outputs without waiting for a clock.
    issue(2'b01, 32'hFFFFFFFF, 32'h00000003, 0, 0);
    repeat (9) @(negedge clk);
    chk("busy_before_reset", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("midop_reset_busy", 64'(busy), 64'd0);
    chk("midop_reset_done", 64'(done), 64'd0);
    chk("midop_reset_hi", 64'(hi), 64'd0);
    chk("midop_reset_lo", 64'(lo), 64'd0);
    hold_hi = '0;
    hold_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 64'(busy), 64'd0);

    // Random operations, back to back, sometimes with a same-cycle MT write
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick(), 1, bit'($urandom_range(0, 1)));
    end

    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
